// File: rtl/dmem_bridge_pkg.sv
// Shared load/store opcodes, FSM state encodings and bus size codes for the
// data-memory bridge.
package dmem_bridge_pkg;

    localparam logic [7:0] ALUOP_LB  = 8'h20;
    localparam logic [7:0] ALUOP_LH  = 8'h21;
    localparam logic [7:0] ALUOP_LWL = 8'h22;
    localparam logic [7:0] ALUOP_LW  = 8'h23;
    localparam logic [7:0] ALUOP_LBU = 8'h24;
    localparam logic [7:0] ALUOP_LHU = 8'h25;
    localparam logic [7:0] ALUOP_LWR = 8'h26;
    localparam logic [7:0] ALUOP_SB  = 8'h28;
    localparam logic [7:0] ALUOP_SH  = 8'h29;
    localparam logic [7:0] ALUOP_SW  = 8'h2B;

    localparam logic [1:0] DMEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] DMEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] DMEM_SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        DMEM_IDLE  = 3'd0,
        DMEM_REQ   = 3'd1,
        DMEM_WAIT  = 3'd2,
        DMEM_DRAIN = 3'd3,
        DMEM_DONE  = 3'd4
    } dmem_state_e;

    // Anything that is not an explicit byte or half access goes out as a word.
    function automatic logic [1:0] dmem_size(input logic [7:0] aluop);
        case (aluop)
            ALUOP_LB, ALUOP_LBU, ALUOP_SB: dmem_size = DMEM_SIZE_BYTE;
            ALUOP_LH, ALUOP_LHU, ALUOP_SH: dmem_size = DMEM_SIZE_HALF;
            default:                       dmem_size = DMEM_SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// SRAM-like request/handshake bus between dmem_bridge (master) and the data
// memory port (slave).
interface dmem_bridge_if;

    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o, data_wstrb_o,
               data_addr_o, data_wdata_o,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o, data_wstrb_o,
               data_addr_o, data_wdata_o,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

endinterface

// File: rtl/dmem_bridge_load_align.sv
// Combinational load-data alignment and sign/zero extension for writeback.
// DMEM_LWLR_EN adds the LWL/LWR merge with the old rt value.
module dmem_bridge_load_align
    import dmem_bridge_pkg::*;
(
    input  logic [7:0]  i_aluop,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

`ifdef DMEM_LWLR_EN
    // ~lane equals 3-lane for a 2-bit lane, so these are 8*(3-a) and 8*a.
    logic [4:0]  w_lwlShift;
    logic [4:0]  w_lwrShift;
    logic [31:0] w_lwlKeep;
    logic [31:0] w_lwrKeep;

    assign w_lwlShift = {~i_lane, 3'b000};
    assign w_lwrShift = {i_lane, 3'b000};
    assign w_lwlKeep  = ~(32'hFFFF_FFFF << w_lwlShift);
    assign w_lwrKeep  = ~(32'hFFFF_FFFF >> w_lwrShift);
`else
    logic w_unusedRt;
    assign w_unusedRt = ^i_rt;
`endif

    always_comb begin
        o_data = i_rdata;
        case (i_aluop)
            ALUOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            ALUOP_LBU: o_data = {24'd0, w_byte};
            ALUOP_LH:  o_data = {{16{w_half[15]}}, w_half};
            ALUOP_LHU: o_data = {16'd0, w_half};
`ifdef DMEM_LWLR_EN
            ALUOP_LWL: o_data = (i_rdata << w_lwlShift) | (i_rt & w_lwlKeep);
            ALUOP_LWR: o_data = (i_rdata >> w_lwrShift) | (i_rt & w_lwrKeep);
`endif
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to SRAM-like bus bridge: launches one access, stalls the pipeline
// until it completes and returns aligned load data. DMEM_LWLR_EN enables LWL/LWR.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              pipeline_stall_i,
    input  logic              mem_en_i,
    input  logic [3:0]        mem_wen_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [7:0]        aluop_i,
    input  logic [DATA_W-1:0] rt_data_i,
    dmem_bridge_if.master     bus,
    output logic              stall_o,
    output logic              load_valid_o,
    output logic [DATA_W-1:0] load_data_o
);

    dmem_state_e       r_state;
    dmem_state_e       w_nextState;
    logic [DATA_W-1:0] r_busAddr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rt;
    logic [DATA_W-1:0] r_loadData;
    logic [3:0]        r_wstrb;
    logic [7:0]        r_aluop;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_wr;
    logic              r_flushSeen;

    logic              w_launch;
    logic              w_capture;
    logic              w_flushed;
    logic [DATA_W-1:0] w_launchAddr;
    logic [DATA_W-1:0] w_aligned;

    assign w_launch  = (r_state == DMEM_IDLE) && mem_en_i && !flush_i;
    assign w_flushed = flush_i || r_flushSeen;

    always_comb begin
        w_launchAddr = mem_addr_i;
`ifdef DMEM_LWLR_EN
        if (aluop_i == ALUOP_LWL || aluop_i == ALUOP_LWR) begin
            w_launchAddr = {mem_addr_i[DATA_W-1:2], 2'b00};
        end
`endif
    end

    // A flush never withdraws an issued request; the response is drained instead.
    always_comb begin
        w_nextState    = r_state;
        w_capture      = 1'b0;
        bus.data_req_o = 1'b0;
        stall_o        = 1'b0;
        load_valid_o   = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                stall_o = w_launch;
                if (w_launch) begin
                    w_nextState = DMEM_REQ;
                end
            end
            DMEM_REQ: begin
                bus.data_req_o = 1'b1;
                stall_o        = 1'b1;
                if (bus.data_addr_ok_i) begin
                    if (bus.data_data_ok_i) begin
                        if (w_flushed) begin
                            w_nextState = DMEM_IDLE;
                        end else begin
                            w_nextState = DMEM_DONE;
                            w_capture   = !r_wr;
                        end
                    end else begin
                        w_nextState = w_flushed ? DMEM_DRAIN : DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                stall_o = 1'b1;
                if (bus.data_data_ok_i) begin
                    if (flush_i) begin
                        w_nextState = DMEM_IDLE;
                    end else begin
                        w_nextState = DMEM_DONE;
                        w_capture   = !r_wr;
                    end
                end else if (flush_i) begin
                    w_nextState = DMEM_DRAIN;
                end
            end
            DMEM_DRAIN: begin
                stall_o = mem_en_i;
                if (bus.data_data_ok_i) begin
                    w_nextState = DMEM_IDLE;
                end
            end
            DMEM_DONE: begin
                load_valid_o = !r_wr;
                if (!pipeline_stall_i || flush_i) begin
                    w_nextState = DMEM_IDLE;
                end
            end
            default: begin
                w_nextState = DMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DMEM_IDLE;
            r_busAddr   <= '0;
            r_wdata     <= '0;
            r_rt        <= '0;
            r_loadData  <= '0;
            r_wstrb     <= 4'b0000;
            r_aluop     <= 8'd0;
            r_lane      <= 2'd0;
            r_size      <= DMEM_SIZE_BYTE;
            r_wr        <= 1'b0;
            r_flushSeen <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_launch) begin
                r_busAddr   <= w_launchAddr;
                r_wdata     <= mem_wdata_i;
                r_rt        <= rt_data_i;
                r_wstrb     <= mem_wen_i;
                r_aluop     <= aluop_i;
                r_lane      <= mem_addr_i[1:0];
                r_size      <= dmem_size(aluop_i);
                r_wr        <= |mem_wen_i;
                r_flushSeen <= 1'b0;
            end else if (r_state == DMEM_REQ && flush_i) begin
                r_flushSeen <= 1'b1;
            end
            if (w_capture) begin
                r_loadData <= w_aligned;
            end
        end
    end

    dmem_bridge_load_align u_align (
        .i_aluop (r_aluop),
        .i_lane  (r_lane),
        .i_rdata (bus.data_rdata_i),
        .i_rt    (r_rt),
        .o_data  (w_aligned)
    );

    assign bus.data_wr_o    = r_wr;
    assign bus.data_size_o  = r_size;
    assign bus.data_wstrb_o = r_wstrb;
    assign bus.data_addr_o  = r_busAddr;
    assign bus.data_wdata_o = r_wdata;
    assign load_data_o      = r_loadData;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus pushes expected bus requests and
// load results, a monitor pops them as the DUT presents them. Honors DMEM_LWLR_EN.
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busTxn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        pipeStall;
    logic        memEn;
    logic [3:0]  memWen;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [7:0]  aluop;
    logic [31:0] rtData;
    logic        stallOut;
    logic        loadValid;
    logic [31:0] loadData;

    int          testsRun = 0;
    int          testsFailed = 0;
    busTxn_t     busQ[$];
    logic [31:0] loadQ[$];
    logic [7:0]  ops[10];

    dmem_bridge_if bus ();

    dmem_bridge #(.DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush),
        .pipeline_stall_i (pipeStall),
        .mem_en_i         (memEn),
        .mem_wen_i        (memWen),
        .mem_addr_i       (memAddr),
        .mem_wdata_i      (memWdata),
        .aluop_i          (aluop),
        .rt_data_i        (rtData),
        .bus              (bus),
        .stall_o          (stallOut),
        .load_valid_o     (loadValid),
        .load_data_o      (loadData)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [1:0] sizeFor(input logic [7:0] op);
        if (op == ALUOP_LB || op == ALUOP_LBU || op == ALUOP_SB) return 2'd0;
        if (op == ALUOP_LH || op == ALUOP_LHU || op == ALUOP_SH) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [3:0] wenFor(input logic [7:0] op, input logic [1:0] a);
        if (op == ALUOP_SB) return 4'b0001 << a;
        if (op == ALUOP_SH) return a[1] ? 4'b1100 : 4'b0011;
        if (op == ALUOP_SW) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] replicate(input logic [7:0] op, input logic [31:0] value);
        if (op == ALUOP_SB) return {4{value[7:0]}};
        if (op == ALUOP_SH) return {2{value[15:0]}};
        return value;
    endfunction

    function automatic logic [31:0] busAddrFor(input logic [7:0] op, input logic [31:0] addr);
`ifdef DMEM_LWLR_EN
        if (op == ALUOP_LWL || op == ALUOP_LWR) return addr & 32'hFFFF_FFFC;
`endif
        if (op == 8'hFF) return 32'd0;
        return addr;
    endfunction

    // Reference result built lane by lane from the architectural load rules.
    function automatic logic [31:0] expectLoad(input logic [7:0] op, input logic [1:0] a,
                                               input logic [31:0] rdata, input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        int          lane;
        lane = int'(a);
        b = rdata[8*lane +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        r = rdata;
        if (op == ALUOP_LB)  r = (b >= 8'd128) ? 32'(b) - 32'd256 : 32'(b);
        if (op == ALUOP_LBU) r = 32'(b);
        if (op == ALUOP_LH)  r = (h >= 16'h8000) ? 32'(h) - 32'h0001_0000 : 32'(h);
        if (op == ALUOP_LHU) r = 32'(h);
`ifdef DMEM_LWLR_EN
        if (op == ALUOP_LWL) begin
            for (int i = 0; i < 4; i++) begin
                r[8*i +: 8] = (i >= 3 - lane) ? rdata[8*(i - (3 - lane)) +: 8] : rt[8*i +: 8];
            end
        end
        if (op == ALUOP_LWR) begin
            for (int i = 0; i < 4; i++) begin
                r[8*i +: 8] = (i <= 3 - lane) ? rdata[8*(i + lane) +: 8] : rt[8*i +: 8];
            end
        end
`else
        if (rt == 32'hFFFF_FFFF && op == 8'hFF) r = 32'd0;
`endif
        return r;
    endfunction

    // One access from launch to return to IDLE; slave timing is given in cycles
    // counted from the first REQ cycle, flushCycle < 0 meaning no flush.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] value,
                                 input logic [31:0] rt, input logic [31:0] rdata,
                                 input int addrDelay, input int dataDelay, input int flushCycle,
                                 input int holdCycles, input bit gap);
        busTxn_t     txn;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        isLoad;
        logic        flushed;
        int          addrCycle;
        int          dataCycle;
        wen       = wenFor(op, addr[1:0]);
        wdata     = replicate(op, value);
        isLoad    = (wen == 4'b0000);
        flushed   = (flushCycle >= 0);
        addrCycle = addrDelay;
        dataCycle = addrDelay + dataDelay;
        txn.wr    = !isLoad;
        txn.size  = sizeFor(op);
        txn.strb  = wen;
        txn.addr  = busAddrFor(op, addr);
        txn.wdata = wdata;
        busQ.push_back(txn);
        if (isLoad && !flushed) loadQ.push_back(expectLoad(op, addr[1:0], rdata, rt));

        memEn = 1'b1; memWen = wen; memAddr = addr; memWdata = wdata; aluop = op; rtData = rt;
        @(negedge clk);
        checkOutput("launchStall", 32'(stallOut), 32'd1);
        @(posedge clk); #1;
        memEn = 1'b0; memWen = 4'($urandom); memAddr = $urandom; memWdata = $urandom;
        aluop = 8'($urandom); rtData = $urandom;

        for (int k = 0; k <= dataCycle; k++) begin
            bus.data_addr_ok_i = (k == addrCycle);
            bus.data_data_ok_i = (k == dataCycle);
            bus.data_rdata_i   = (k == dataCycle) ? rdata : $urandom;
            flush              = (k == flushCycle);
            @(negedge clk);
            checkOutput("reqHeld", 32'(bus.data_req_o), 32'(k <= addrCycle));
            checkOutput("busyStall", 32'(stallOut), 32'(!(k > addrCycle && flushed && flushCycle < k)));
            @(posedge clk); #1;
        end
        bus.data_addr_ok_i = 1'b0;
        bus.data_data_ok_i = 1'b0;
        bus.data_rdata_i   = $urandom;
        flush              = 1'b0;

        if (!flushed) begin
            for (int j = 0; j <= holdCycles; j++) begin
                pipeStall = (j < holdCycles);
                @(negedge clk);
                checkOutput("doneStall", 32'(stallOut), 32'd0);
                checkOutput("doneValid", 32'(loadValid), 32'(isLoad));
                @(posedge clk); #1;
            end
            pipeStall = 1'b0;
        end

        if (gap) begin
            bus.data_data_ok_i = 1'b1;
            @(negedge clk);
            checkOutput("idleStall", 32'(stallOut), 32'd0);
            checkOutput("idleReq", 32'(bus.data_req_o), 32'd0);
            checkOutput("idleValid", 32'(loadValid), 32'd0);
            @(posedge clk); #1;
            bus.data_data_ok_i = 1'b0;
        end
    endtask

    // Monitor: compares accepted bus requests and each newly valid load result.
    initial begin
        busTxn_t     exp;
        logic        prevValid;
        logic [31:0] heldExpected;
        prevValid    = 1'b0;
        heldExpected = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
            end else begin
                if (bus.data_req_o && bus.data_addr_ok_i) begin
                    if (busQ.size() == 0) begin
                        checkOutput("busUnexpected", 32'd1, 32'd0);
                    end else begin
                        exp = busQ.pop_front();
                        checkOutput("busWr", 32'(bus.data_wr_o), 32'(exp.wr));
                        checkOutput("busSize", 32'(bus.data_size_o), 32'(exp.size));
                        checkOutput("busStrb", 32'(bus.data_wstrb_o), 32'(exp.strb));
                        checkOutput("busAddr", bus.data_addr_o, exp.addr);
                        checkOutput("busWdata", bus.data_wdata_o, exp.wdata);
                    end
                end
                if (loadValid && !prevValid) begin
                    if (loadQ.size() == 0) begin
                        checkOutput("loadUnexpected", 32'd1, 32'd0);
                    end else begin
                        heldExpected = loadQ.pop_front();
                        checkOutput("loadData", loadData, heldExpected);
                    end
                end else if (loadValid && prevValid) begin
                    checkOutput("loadHold", loadData, heldExpected);
                end
                prevValid = loadValid;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] aborting on cycle budget");
    end

    initial begin
        ops = '{ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW,
                ALUOP_LWL, ALUOP_LWR, ALUOP_SB, ALUOP_SH, ALUOP_SW};
        rst = 1'b1; flush = 1'b0; pipeStall = 1'b0; memEn = 1'b0; memWen = 4'b0000;
        memAddr = 32'd0; memWdata = 32'd0; aluop = 8'd0; rtData = 32'd0;
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0; bus.data_rdata_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReq", 32'(bus.data_req_o), 32'd0);
        checkOutput("rstWr", 32'(bus.data_wr_o), 32'd0);
        checkOutput("rstSize", 32'(bus.data_size_o), 32'd0);
        checkOutput("rstStrb", 32'(bus.data_wstrb_o), 32'd0);
        checkOutput("rstAddr", bus.data_addr_o, 32'd0);
        checkOutput("rstWdata", bus.data_wdata_o, 32'd0);
        checkOutput("rstStall", 32'(stallOut), 32'd0);
        checkOutput("rstValid", 32'(loadValid), 32'd0);
        checkOutput("rstData", loadData, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(ALUOP_LW,  32'h0000_1000, 32'd0, 32'd0, 32'h1234_5678, 0, 3, -1, 0, 1);
        applyStimulus(ALUOP_LB,  32'h0000_1003, 32'd0, 32'd0, 32'h80AB_CDEF, 1, 1, -1, 0, 0);
        applyStimulus(ALUOP_LBU, 32'h0000_1003, 32'd0, 32'd0, 32'h80AB_CDEF, 0, 0, -1, 0, 1);
        applyStimulus(ALUOP_LHU, 32'h0000_1002, 32'd0, 32'd0, 32'h80AB_CDEF, 0, 2, -1, 0, 0);
        applyStimulus(ALUOP_SW,  32'h0000_2000, 32'hDEAD_BEEF, 32'd0, 32'd0, 0, 0, -1, 0, 1);
        applyStimulus(ALUOP_LW,  32'h0000_1000, 32'd0, 32'd0, 32'hCAFE_F00D, 0, 3, 1, 0, 1);
        applyStimulus(ALUOP_LW,  32'h0000_1004, 32'd0, 32'd0, 32'h0BAD_0BAD, 3, 2, 1, 0, 1);
        applyStimulus(ALUOP_LW,  32'h0000_1008, 32'd0, 32'd0, 32'h5555_AAAA, 0, 1, -1, 4, 0);
        applyStimulus(ALUOP_LH,  32'h0000_100A, 32'd0, 32'd0, 32'h9234_5678, 0, 0, -1, 0, 1);
        applyStimulus(ALUOP_LWL, 32'h0000_3001, 32'd0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, -1, 0, 1);
        applyStimulus(ALUOP_LWR, 32'h0000_3002, 32'd0, 32'h1122_3344, 32'hAABB_CCDD, 1, 0, -1, 0, 1);

        memEn = 1'b1; memWen = 4'b0000; memAddr = 32'h0000_4000; aluop = ALUOP_LW;
        @(posedge clk); #1;
        memEn = 1'b0;
        @(negedge clk);
        checkOutput("midReqBefore", 32'(bus.data_req_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midReqAfter", 32'(bus.data_req_o), 32'd0);
        checkOutput("midStallAfter", 32'(stallOut), 32'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 200; n++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            int          aDly;
            int          dDly;
            int          fCyc;
            op   = ops[$urandom_range(0, 9)];
            addr = $urandom;
            if (sizeFor(op) == 2'd1) addr[0] = 1'b0;
            if (sizeFor(op) == 2'd2 && op != ALUOP_LWL && op != ALUOP_LWR) addr[1:0] = 2'b00;
            aDly = $urandom_range(0, 3);
            dDly = $urandom_range(0, 3);
            fCyc = -1;
            if ($urandom_range(0, 3) == 0) begin
                fCyc = $urandom_range(0, (dDly == 0) ? aDly + dDly : aDly + dDly - 1);
            end
            applyStimulus(op, addr, $urandom, $urandom, $urandom, aDly, dDly, fCyc,
                          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        checkOutput("busQEmpty", 32'(busQ.size()), 32'd0);
        checkOutput("loadQEmpty", 32'(loadQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
